tim_ccu: RTL
============

# tim_ccu

Capture/compare unit sitting directly downstream of the general-purpose timer. It consumes the timer's running count and update (wrap) pulse, and drives NUM_CH channels. Each channel is independently configured as PWM output, toggle-on-match output or input capture. Sticky per-channel flags are ORed into a single maskable interrupt for the core's interrupt logic.

## Interface
- NUM_CH, 4: number of capture/compare channels (1..8)
- CNT_W, 16: timer count width; matches the timer's TIM_CNT width
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- tim_cnt  in  CNT_W  timer count value; may change at most once per clk
- tim_update  in  1  one-clk pulse when the timer wraps/reloads (counter reached ARR)
- ch_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 PWM, 10 toggle, 11 capture
- ccr_we  in  NUM_CH  per-channel write strobe for the compare register
- ccr_wdata  in  CNT_W  write data shared by all channels
- cap_in  in  NUM_CH  asynchronous capture inputs
- irq_en  in  NUM_CH  per-channel interrupt enable
- flag_clr  in  NUM_CH  one-clk clear strobes for ch_flag
- ccr_rdata  out  NUM_CH*CNT_W  active compare value or last captured value, channel i at [CNT_W*i +: CNT_W]
- ch_out  out  NUM_CH  registered channel outputs
- ch_flag  out  NUM_CH  sticky match/capture flags
- ccu_irq  out  1  OR over i of (ch_flag[i] & irq_en[i]), registered

## Operation
- cnt_q: tim_cnt registered every clk; cnt_chg = (tim_cnt != cnt_q).
- Match event, channel i: cnt_chg && tim_cnt == ccr_act[i]. Exactly one event per count value, whatever the prescale.
- Mode off: ch_out[i]=0, no events, ccr still writable.
- PWM: ch_out[i] <= (tim_cnt < ccr_act[i]). ccr_act=0 gives constant 0. ccr_act greater than the counter's maximum gives constant 1. Match events set ch_flag.
- Toggle: ch_out[i] inverts on each match event; ch_flag set.
- Capture: cap_in[i] passes through a 2-flop synchronizer and a rising-edge detector. On an edge, ccr_act[i] <= tim_cnt and ch_flag[i] set. ch_out[i]=0.
- Channel mode change (ch_mode field differs from its registered copy): ch_out[i] <= 0 on that cycle.
- ch_flag: set has priority over flag_clr in the same cycle.
- Capture vs ccr_we in the same cycle in capture mode: capture wins, the write is dropped.

## Timing
- Reset: ch_out=0, ch_flag=0, ccu_irq=0, all ccr_act=0, all ccr_shadow=0, cnt_q=0, sync/edge flops=0, mode copies=00.
- tim_cnt change -> ch_out/ch_flag updated on the same rising edge that registers cnt_q. Visible 1 clk after tim_cnt changes.
- ch_flag -> ccu_irq: +1 clk.
- cap_in rise -> ccr_act/ch_flag update: 3 clk (2 sync + edge register). Minimum detectable high/low pulse: 2 clk.
- ccr_we (no preload): ccr_act updated at that edge; ccr_rdata reflects it next cycle.
- rst_n low mid-period: all state returns to reset values at the next edge, regardless of tim_update or ccr_we.

## Configuration
- TIM_CCU_PRELOAD_EN defined:
  - In PWM and toggle modes, ccr_we writes ccr_shadow[i]. All shadows copy to ccr_act on tim_update.
  - If ccr_we and tim_update coincide, ccr_act takes the old shadow and the new data lands in the shadow for the next update.
  - Capture-mode writes bypass the shadow.
- TIM_CCU_PRELOAD_EN undefined: no shadow registers. ccr_we writes ccr_act directly. tim_update is ignored.

## Test plan
- PWM: ch0 mode 01, ccr=3, tim_cnt ramps 0..9 then 0 -> ch_out[0] is high for counts 0,1,2 and low for 3..9. ch_flag[0] is set 1 clk after count 3. With irq_en[0]=1, ccu_irq follows 1 clk later.
- Toggle: ch1 mode 10, ccr=5, tim_cnt held at 5 for 8 clks each period -> ch_out[1] inverts once per period.
- Capture: ch2 mode 11, tim_cnt=0x1234, cap_in[2] rises -> ccr_rdata ch2=0x1234 and ch_flag[2]=1 exactly 3 clks later. A 1-clk pulse on cap_in is not guaranteed to capture.
- Flag priority: flag_clr[0] asserted on the same cycle as a new match -> ch_flag[0] stays 1. flag_clr alone -> ch_flag 0 next clk, ccu_irq 0 one clk after that.
- Preload (macro on): PWM ccr=3, write 7 mid-period -> duty stays 3 until tim_update, then 7. Write coincident with tim_update -> takes effect at the following update. Macro off -> 7 applies immediately.
- Reset mid-run: rst_n low for 1 clk while ch_out=1 and flags set -> all outputs 0 and ccr_rdata 0 next clk.

Source files
------------

// File: rtl/tim_ccu.sv
// Capture/compare unit: NUM_CH channels of PWM, toggle-on-match or input capture driven by the timer count.
// Define TIM_CCU_PRELOAD_EN to add per-channel shadow compare registers that load on tim_update.
module tim_ccu #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CNT_W-1:0]          tim_cnt,
  input  logic                      tim_update,
  input  logic [2*NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH-1:0]         ccr_we,
  input  logic [CNT_W-1:0]          ccr_wdata,
  input  logic [NUM_CH-1:0]         cap_in,
  input  logic [NUM_CH-1:0]         irq_en,
  input  logic [NUM_CH-1:0]         flag_clr,
  output logic [NUM_CH*CNT_W-1:0]   ccr_rdata,
  output logic [NUM_CH-1:0]         ch_out,
  output logic [NUM_CH-1:0]         ch_flag,
  output logic                      ccu_irq
);

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_PWM = 2'b01;
  localparam logic [1:0] MODE_TOG = 2'b10;
  localparam logic [1:0] MODE_CAP = 2'b11;

  logic [CNT_W-1:0] cnt_reg;
  logic             cnt_chg;
  logic             irq_reg;

  assign cnt_chg = (tim_cnt != cnt_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      irq_reg <= 1'b0;
    end else begin
      cnt_reg <= tim_cnt;
      irq_reg <= |(ch_flag & irq_en);
    end
  end

  assign ccu_irq = irq_reg;

`ifndef TIM_CCU_PRELOAD_EN
  logic unused_update;
  assign unused_update = tim_update;
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]       mode;
      logic [1:0]       mode_reg;
      logic [CNT_W-1:0] ccr_act_reg;
      logic [CNT_W-1:0] ccr_act_next;
      logic [2:0]       cap_sync_reg;
      logic             out_reg;
      logic             out_next;
      logic             flag_reg;
      logic             flag_next;
      logic             cmp_mode;
      logic             match;
      logic             cap_evt;
`ifdef TIM_CCU_PRELOAD_EN
      logic [CNT_W-1:0] ccr_shadow_reg;
      logic [CNT_W-1:0] ccr_shadow_next;
`endif

      assign mode     = ch_mode[2*gi +: 2];
      assign cmp_mode = (mode == MODE_PWM) || (mode == MODE_TOG);
      assign match    = cmp_mode && cnt_chg && (tim_cnt == ccr_act_reg);
      // [0],[1] synchronize; [2] holds the previous synchronized level for edge detection
      assign cap_evt  = (mode == MODE_CAP) && cap_sync_reg[1] && !cap_sync_reg[2];

      always_comb begin
        out_next = out_reg;
        if (mode != mode_reg) begin
          out_next = 1'b0;
        end else begin
          case (mode)
            MODE_PWM: out_next = (tim_cnt < ccr_act_reg);
            MODE_TOG: if (match) out_next = !out_reg;
            default:  out_next = 1'b0;
          endcase
        end
      end

      always_comb begin
        flag_next = flag_reg;
        if (match || cap_evt)
          flag_next = 1'b1;
        else if (flag_clr[gi])
          flag_next = 1'b0;
      end

`ifdef TIM_CCU_PRELOAD_EN
      // Off/capture-mode writes land in both registers so a stale shadow never reappears later.
      always_comb begin
        ccr_act_next    = ccr_act_reg;
        ccr_shadow_next = ccr_shadow_reg;
        if (cap_evt) begin
          ccr_act_next = tim_cnt;
        end else if (ccr_we[gi]) begin
          ccr_shadow_next = ccr_wdata;
          if (!cmp_mode) ccr_act_next = ccr_wdata;
        end
        if (tim_update && cmp_mode)
          ccr_act_next = ccr_shadow_reg;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) ccr_shadow_reg <= '0;
        else        ccr_shadow_reg <= ccr_shadow_next;
      end
`else
      always_comb begin
        ccr_act_next = ccr_act_reg;
        if (cap_evt)
          ccr_act_next = tim_cnt;
        else if (ccr_we[gi])
          ccr_act_next = ccr_wdata;
      end
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mode_reg     <= MODE_OFF;
          ccr_act_reg  <= '0;
          cap_sync_reg <= '0;
          out_reg      <= 1'b0;
          flag_reg     <= 1'b0;
        end else begin
          mode_reg     <= mode;
          ccr_act_reg  <= ccr_act_next;
          cap_sync_reg <= {cap_sync_reg[1:0], cap_in[gi]};
          out_reg      <= out_next;
          flag_reg     <= flag_next;
        end
      end

      assign ch_out[gi]                    = out_reg;
      assign ch_flag[gi]                   = flag_reg;
      assign ccr_rdata[CNT_W*gi +: CNT_W]  = ccr_act_reg;
    end
  endgenerate

endmodule
